// File: rtl/ili9341_xfer_seq.sv
// ILI9341 frame sequencer: one opcode byte (DC=0) then cmd_len data bytes (DC=1) onto a byte SPI engine.
// Define ILI_HWRST_EN to add the lcd_rst_n pulse (RST_CYC low, then RST_WAIT settle) after reset.
module ili9341_xfer_seq #(
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned CS_GAP   = 4
`ifdef ILI_HWRST_EN
  ,
  parameter int unsigned RST_CYC  = 1000,
  parameter int unsigned RST_WAIT = 5000
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_byte,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             dat_valid,
  output logic             dat_ready,
  input  logic [7:0]       dat_byte,
  output logic             spi_send,
  output logic [7:0]       spi_byte,
  input  logic             spi_done,
  output logic             lcd_dc,
  output logic             lcd_cs_n,
`ifdef ILI_HWRST_EN
  output logic             lcd_rst_n,
`endif
  output logic             busy
);

  localparam int unsigned GapW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  typedef enum logic [3:0] {
    StRstLo, StRstHi, StIdle, StCmdTx, StCmdWt, StDatRq, StDatTx, StDatWt, StGap
  } state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        byte_q, byte_d;
  logic              dc_q, dc_d;
  logic [GapW-1:0]   gap_q, gap_d;

`ifdef ILI_HWRST_EN
  localparam int unsigned RstMax = (RST_CYC > RST_WAIT) ? RST_CYC : RST_WAIT;
  localparam int unsigned RstW   = (RstMax > 1) ? $clog2(RstMax) : 1;
  logic [RstW-1:0] rcnt_q, rcnt_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRstLo;
      cnt_q   <= '0;
      byte_q  <= 8'h00;
      dc_q    <= 1'b0;
      gap_q   <= '0;
`ifdef ILI_HWRST_EN
      rcnt_q  <= RstW'(RST_CYC - 1);
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      dc_q    <= dc_d;
      gap_q   <= gap_d;
`ifdef ILI_HWRST_EN
      rcnt_q  <= rcnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    dc_d      = dc_q;
    gap_d     = gap_q;
`ifdef ILI_HWRST_EN
    rcnt_d    = rcnt_q;
`endif
    cmd_ready = 1'b0;
    dat_ready = 1'b0;
    spi_send  = 1'b0;
    lcd_cs_n  = 1'b1;
    busy      = 1'b1;

    unique case (state_q)
      StRstLo: begin
`ifdef ILI_HWRST_EN
        if (rcnt_q == '0) begin
          state_d = StRstHi;
          rcnt_d  = RstW'(RST_WAIT - 1);
        end else begin
          rcnt_d  = rcnt_q - 1'b1;
        end
`else
        state_d = StIdle;
`endif
      end
      StRstHi: begin
`ifdef ILI_HWRST_EN
        if (rcnt_q == '0) state_d = StIdle;
        else              rcnt_d  = rcnt_q - 1'b1;
`else
        state_d = StIdle;
`endif
      end
      StIdle: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          byte_d  = cmd_byte;
          cnt_d   = cmd_len;
          dc_d    = 1'b0;
          state_d = StCmdTx;
        end
      end
      StCmdTx: begin
        lcd_cs_n = 1'b0;
        spi_send = 1'b1;
        state_d  = StCmdWt;
      end
      StCmdWt, StDatWt: begin
        lcd_cs_n = 1'b0;
        // cnt already counts the byte in flight, so zero here means the frame is complete
        if (spi_done) begin
          if (cnt_q == '0) begin
            state_d = StGap;
            gap_d   = GapW'(CS_GAP - 1);
          end else begin
            state_d = StDatRq;
          end
        end
      end
      StDatRq: begin
        lcd_cs_n  = 1'b0;
        dat_ready = 1'b1;
        if (dat_valid) begin
          byte_d  = dat_byte;
          dc_d    = 1'b1;
          state_d = StDatTx;
        end
      end
      StDatTx: begin
        lcd_cs_n = 1'b0;
        spi_send = 1'b1;
        cnt_d    = cnt_q - 1'b1;
        state_d  = StDatWt;
      end
      StGap: begin
        if (gap_q == '0) state_d = StIdle;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign spi_byte = byte_q;
  assign lcd_dc   = dc_q;
`ifdef ILI_HWRST_EN
  assign lcd_rst_n = (state_q != StRstLo);
`endif

endmodule

// File: tb/tb_ili9341_xfer_seq.sv
// Randomized bench for ili9341_xfer_seq: frame-level byte queue model plus a randomized SPI responder.
module tb_ili9341_xfer_seq;

  localparam int unsigned LEN_W  = 4;
  localparam int unsigned CS_GAP = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [7:0]       cmd_byte = 8'h00;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             dat_valid = 1'b0;
  logic             dat_ready;
  logic [7:0]       dat_byte = 8'h00;
  logic             spi_send;
  logic [7:0]       spi_byte;
  logic             spi_done = 1'b0;
  logic             lcd_dc;
  logic             lcd_cs_n;
  logic             busy;
`ifdef ILI_HWRST_EN
  logic             lcd_rst_n;
`endif

  ili9341_xfer_seq #(
    .LEN_W    (LEN_W),
    .CS_GAP   (CS_GAP)
`ifdef ILI_HWRST_EN
    ,
    .RST_CYC  (10),
    .RST_WAIT (20)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_byte  (cmd_byte),
    .cmd_len   (cmd_len),
    .dat_valid (dat_valid),
    .dat_ready (dat_ready),
    .dat_byte  (dat_byte),
    .spi_send  (spi_send),
    .spi_byte  (spi_byte),
    .spi_done  (spi_done),
    .lcd_dc    (lcd_dc),
    .lcd_cs_n  (lcd_cs_n),
`ifdef ILI_HWRST_EN
    .lcd_rst_n (lcd_rst_n),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected byte stream {dc, byte} in transmit order, pushed per frame by the stimulus.
  logic [8:0] exp_q[$];
  logic [7:0] dbuf [0:15];

  logic       outstanding = 1'b0;
  logic       done_pend   = 1'b0;
  logic       frame_seen  = 1'b0;
  logic [7:0] out_byte    = 8'h00;
  logic       out_dc      = 1'b0;
  int         dly = 0;
  int         rem = 0;
  int         gap_cnt = 0;

  // SPI engine model and protocol monitor; samples on the falling edge.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      exp_q.delete();
      outstanding = 1'b0;
      done_pend   = 1'b0;
      frame_seen  = 1'b0;
      rem         = 0;
      gap_cnt     = 0;
      spi_done    = 1'b0;
    end else begin
      spi_done = 1'b0;
      check_eq("rdy_excl", 32'(cmd_ready & dat_ready), 32'd0);
      check_eq("busy_idle", 32'(busy), 32'(!cmd_ready));
      if (done_pend) begin
        check_eq("done_to_rdy", 32'(dat_ready), 32'(rem != 0));
        done_pend = 1'b0;
      end
      if (cmd_valid && cmd_ready) rem = int'(cmd_len);
      if (dat_valid && dat_ready) rem--;
      if (frame_seen && cmd_ready) begin
        check_eq("cs_gap", 32'(gap_cnt), 32'(CS_GAP));
        frame_seen = 1'b0;
        gap_cnt    = 0;
      end else if (frame_seen && lcd_cs_n) begin
        gap_cnt++;
      end
      if (outstanding) begin
        check_eq("send_busy", 32'(spi_send), 32'd0);
        check_eq("byte_hold", 32'(spi_byte), 32'(out_byte));
        check_eq("dc_hold", 32'(lcd_dc), 32'(out_dc));
        check_eq("cs_hold", 32'(lcd_cs_n), 32'd0);
        if (dly == 0) begin
          spi_done    = 1'b1;
          outstanding = 1'b0;
          done_pend   = 1'b1;
        end else begin
          dly--;
        end
      end else if (spi_send) begin
        check_eq("extra_send", 32'(exp_q.size() != 0), 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h000;
        check_eq("send_byte", 32'(spi_byte), 32'(e[7:0]));
        check_eq("send_dc", 32'(lcd_dc), 32'(e[8]));
        check_eq("send_cs", 32'(lcd_cs_n), 32'd0);
        out_byte    = spi_byte;
        out_dc      = lcd_dc;
        outstanding = 1'b1;
        frame_seen  = 1'b1;
        dly         = $urandom_range(0, 4);
      end else if ($urandom_range(0, 7) == 0) begin
        spi_done = 1'b1;  // spurious pulse; must be ignored
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 500) begin
      tick();
      n++;
    end
    check_eq("idle_wait", 32'(cmd_ready), 32'd1);
  endtask

  // Sends opcode plus len bytes from dbuf; stalls dat_valid for stall_len cycles before byte
  // stall_at; returns right after the handshake of byte abort_at (abort_at < 0: full frame).
  task automatic send_frame(input logic [7:0] op, input int len, input int stall_at,
                            input int stall_len, input int abort_at);
    int n;
    exp_q.push_back({1'b0, op});
    for (int i = 0; i < len; i++) exp_q.push_back({1'b1, dbuf[i]});
    cmd_valid = 1'b1;
    cmd_byte  = op;
    cmd_len   = len[LEN_W-1:0];
    n = 0;
    while (!cmd_ready && n < 500) begin
      tick();
      n++;
    end
    check_eq("cmd_wait", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_byte  = 8'($urandom);
    check_eq("cmd_lat", 32'(spi_send), 32'd1);
    for (int i = 0; i < len; i++) begin
      if (i == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          tick();
          if (dat_ready) check_eq("stall_quiet", 32'({spi_send, lcd_cs_n}), 32'd0);
        end
        check_eq("stall_rdy", 32'(dat_ready), 32'd1);
      end else begin
        repeat ($urandom_range(0, 2)) tick();
      end
      dat_valid = 1'b1;
      dat_byte  = dbuf[i];
      n = 0;
      while (!dat_ready && n < 500) begin
        tick();
        n++;
      end
      check_eq("dat_wait", 32'(dat_ready), 32'd1);
      tick();
      dat_valid = 1'b0;
      dat_byte  = 8'($urandom);
      check_eq("dat_lat", 32'(spi_send), 32'd1);
      if (i == abort_at) return;
    end
  endtask

  initial begin
    int lo;
    int hi;
    repeat (2) tick();
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_dat_ready", 32'(dat_ready), 32'd0);
    check_eq("rst_spi_send", 32'(spi_send), 32'd0);
    check_eq("rst_spi_byte", 32'(spi_byte), 32'd0);
    check_eq("rst_lcd_dc", 32'(lcd_dc), 32'd0);
    check_eq("rst_cs_n", 32'(lcd_cs_n), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
`ifdef ILI_HWRST_EN
    lo = 0;
    while (!lcd_rst_n && lo < 100) begin
      lo++;
      tick();
    end
    check_eq("hwrst_low", 32'(lo), 32'd10);
    hi = 0;
    while (!cmd_ready && hi < 100) begin
      check_eq("hwrst_busy", 32'(busy), 32'd1);
      hi++;
      tick();
    end
    check_eq("hwrst_wait", 32'(hi), 32'd20);
`else
    lo = 0;
    hi = 0;
    check_eq("exit_busy", 32'(busy), 32'd1);
    tick();
    check_eq("exit_idle", 32'(cmd_ready), 32'd1);
    check_eq("exit_busy_lo", 32'(busy), 32'(lo + hi));
`endif

    send_frame(8'h01, 0, -1, 0, -1);
    wait_idle();
    dbuf[0] = 8'h00; dbuf[1] = 8'h00; dbuf[2] = 8'h00; dbuf[3] = 8'hEF;
    send_frame(8'h2A, 4, -1, 0, -1);
    wait_idle();
    dbuf[0] = 8'h11; dbuf[1] = 8'h22; dbuf[2] = 8'h33;
    send_frame(8'h2C, 3, 1, 20, -1);
    wait_idle();
    for (int i = 0; i < 15; i++) dbuf[i] = 8'($urandom);
    send_frame(8'h2C, 15, -1, 0, -1);  // maximum length for LEN_W=4
    wait_idle();

    // Back-to-back random frames: cmd_valid rises while the previous frame is still busy.
    for (int f = 0; f < 25; f++) begin
      int len;
      len = $urandom_range(0, 6);
      for (int i = 0; i < len; i++) dbuf[i] = 8'($urandom);
      send_frame(8'($urandom), len, -1, 0, -1);
    end
    wait_idle();

    // Abort a len-4 frame while its third byte is being sent.
    for (int i = 0; i < 4; i++) dbuf[i] = 8'hA0 + 8'(i);
    send_frame(8'h2C, 4, -1, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("abort_cs_n", 32'(lcd_cs_n), 32'd1);
    check_eq("abort_send", 32'(spi_send), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd1);
    check_eq("abort_byte", 32'(spi_byte), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    send_frame(8'h29, 0, -1, 0, -1);
    wait_idle();
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
